// File: rtl/axi4lite_ram_slave_if.sv
// AXI4-Lite bus bundle between the cache controller (master) and the backing RAM (slave).
interface axi4lite_ram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      s_awvalid;
    logic                      s_awready;
    logic [ADDR_WIDTH-1:0]     s_awaddr;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [DATA_WIDTH-1:0]     s_wdata;
    logic [DATA_WIDTH/8-1:0]   s_wstrb;
    logic                      s_bvalid;
    logic                      s_bready;
    logic [1:0]                s_bresp;
    logic                      s_arvalid;
    logic                      s_arready;
    logic [ADDR_WIDTH-1:0]     s_araddr;
    logic                      s_rvalid;
    logic                      s_rready;
    logic [DATA_WIDTH-1:0]     s_rdata;
    logic [1:0]                s_rresp;

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp
    );

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp
    );
endinterface

// File: rtl/axi4lite_ram_slave.sv
// Word-addressed AXI4-Lite RAM with independent write/read FSMs and a configurable read wait.
// Define AXI_RAM_ERR_EN for SLVERR on out-of-range words; otherwise addresses wrap modulo MEM_DEPTH.
module axi4lite_ram_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4lite_ram_slave_if.slave  s
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_W);
    localparam int IDX_FULL_W = ADDR_WIDTH - OFF;
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'b00, R_WAIT = 2'b01, R_DATA = 2'b10} r_state_e;

    function automatic logic [DATA_WIDTH-1:0] strobe_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic                   awready_q, awready_d, wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;

    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic                   aw_hs_s, w_hs_s, ar_hs_s, wcommit_s, w_oor_s, r_oor_s;
    logic [ADDR_WIDTH-1:0]  waddr_s, raddr_s;
    logic [DATA_WIDTH-1:0]  wdata_s, rword_s;
    logic [STRB_W-1:0]      wstrb_s;
    logic [IDX_FULL_W-1:0]  widx_full_s, ridx_full_s;
    logic [IDX_W-1:0]       widx_s, ridx_s;
    logic                   unused_s;

    assign aw_hs_s = s.s_awvalid & awready_q;
    assign w_hs_s  = s.s_wvalid & wready_q;
    assign ar_hs_s = s.s_arvalid & arready_q;

    // The commit may happen on the same edge a channel arrives, so take live bus values then.
    assign waddr_s     = aw_held_q ? awaddr_q : s.s_awaddr;
    assign wdata_s     = w_held_q ? wdata_q : s.s_wdata;
    assign wstrb_s     = w_held_q ? wstrb_q : s.s_wstrb;
    assign raddr_s     = (r_state_q == R_IDLE) ? s.s_araddr : araddr_q;
    assign widx_full_s = waddr_s[ADDR_WIDTH-1:OFF];
    assign ridx_full_s = raddr_s[ADDR_WIDTH-1:OFF];
    assign widx_s      = widx_full_s[IDX_W-1:0];
    assign ridx_s      = ridx_full_s[IDX_W-1:0];
    assign rword_s     = mem_q[ridx_s];

`ifdef AXI_RAM_ERR_EN
    assign w_oor_s = (widx_full_s >= IDX_FULL_W'(MEM_DEPTH));
    assign r_oor_s = (ridx_full_s >= IDX_FULL_W'(MEM_DEPTH));
`else
    assign w_oor_s = 1'b0;
    assign r_oor_s = 1'b0;
`endif

    assign unused_s = ^{waddr_s[OFF-1:0], raddr_s[OFF-1:0], widx_full_s, ridx_full_s};

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!rst && wcommit_s && !w_oor_s) begin
            mem_q[widx_s] <= strobe_merge(mem_q[widx_s], wdata_s, wstrb_s);
        end
    end

    // Write channel next-state: capture AW and W independently, commit once both are held
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wcommit_s = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s.s_awaddr;
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_hs_s) begin
                    w_held_d = 1'b1;
                    wdata_d  = s.s_wdata;
                    wstrb_d  = s.s_wstrb;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    wcommit_s = 1'b1;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_oor_s ? RESP_SLVERR : RESP_OKAY;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = ~aw_held_d;
                    wready_d  = ~w_held_d;
                end
            end
            W_RESP: begin
                if (s.s_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Read channel next-state: optional wait countdown, then registered data held until rready
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    araddr_d  = s.s_araddr;
                    arready_d = 1'b0;
                    if (READ_LATENCY == 0) begin
                        r_state_d = R_DATA;
                        rvalid_d  = 1'b1;
                        rdata_d   = r_oor_s ? {DATA_WIDTH{1'b0}} : rword_s;
                        rresp_d   = r_oor_s ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_state_d = R_WAIT;
                        cnt_d     = 4'(READ_LATENCY - 1);
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_oor_s ? {DATA_WIDTH{1'b0}} : rword_s;
                    rresp_d   = r_oor_s ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (s.s_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State and output registers; readies come up on the first cycle after reset drops
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            araddr_q  <= {ADDR_WIDTH{1'b0}};
            cnt_q     <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s.s_awready = awready_q;
    assign s.s_wready  = wready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// Directed scoreboard bench for axi4lite_ram_slave (32-bit data, 1024 words, READ_LATENCY 2).
module tb_axi4lite_ram_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;
`ifdef AXI_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem_m [int];
    logic [1:0]  exp_b_q [$];
    rexp_t       exp_r_q [$];

    axi4lite_ram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_ram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_idx(input logic [31:0] addr, output logic oor);
        int idx;
        idx = int'(addr >> 2);
        if (ERR_EN) begin
            oor = (idx >= DEPTH);
        end else begin
            oor = 1'b0;
            idx = idx % DEPTH;
        end
        return idx;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay, input int bhold);
        logic        oor;
        int          idx;
        int          cyc;
        bit          aw_pend, w_pend, aw_go, w_go;
        logic [31:0] word;
        logic [1:0]  exp_b;
        idx = model_idx(addr, oor);
        if (oor) begin
            exp_b_q.push_back(2'b10);
        end else begin
            exp_b_q.push_back(2'b00);
            word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
            end
            mem_m[idx] = word;
        end
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        cyc     = 0;
        bus.s_awaddr  = addr;
        bus.s_wdata   = data;
        bus.s_wstrb   = strb;
        bus.s_wvalid  = 1'b1;
        bus.s_awvalid = (aw_delay == 0);
        while ((aw_pend || w_pend) && cyc < 50) begin
            aw_go = aw_pend && bus.s_awvalid && bus.s_awready;
            w_go  = w_pend && bus.s_wready;
            step();
            cyc++;
            if (aw_go) begin aw_pend = 1'b0; bus.s_awvalid = 1'b0; end
            if (w_go)  begin w_pend = 1'b0;  bus.s_wvalid = 1'b0;  end
            if (aw_pend && w_pend == 1'b0) begin
                chk("wready_low_after_w_capture", bus.s_wready, 1'b0);
                chk("bvalid_before_aw", bus.s_bvalid, 1'b0);
            end
            if (aw_pend && cyc >= aw_delay) bus.s_awvalid = 1'b1;
        end
        chk("wr_handshake_timeout", aw_pend | w_pend, 1'b0);
        chk("bvalid_latency", bus.s_bvalid, 1'b1);
        exp_b = exp_b_q.pop_front();
        for (int i = 0; i < bhold; i++) begin
            chk("bvalid_hold", bus.s_bvalid, 1'b1);
            chk("bresp_hold", bus.s_bresp, exp_b);
            chk("awready_hold", bus.s_awready, 1'b0);
            chk("wready_hold", bus.s_wready, 1'b0);
            step();
        end
        chk("bresp", bus.s_bresp, exp_b);
        bus.s_bready = 1'b1;
        step();
        bus.s_bready = 1'b0;
        chk("bvalid_clear", bus.s_bvalid, 1'b0);
        chk("awready_reopen", bus.s_awready, 1'b1);
        chk("wready_reopen", bus.s_wready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rhold);
        logic  oor;
        int    idx;
        int    cyc;
        int    n;
        bit    hs, go;
        rexp_t e;
        idx = model_idx(addr, oor);
        if (oor) begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end else begin
            e.data = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            e.resp = 2'b00;
        end
        exp_r_q.push_back(e);
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        hs  = 1'b0;
        cyc = 0;
        while (!hs && cyc < 50) begin
            go = bus.s_arready;
            step();
            cyc++;
            if (go) begin hs = 1'b1; bus.s_arvalid = 1'b0; end
        end
        chk("rd_handshake_timeout", hs, 1'b1);
        n = 0;
        while (!bus.s_rvalid && n < 40) begin
            chk("arready_during_wait", bus.s_arready, 1'b0);
            step();
            n++;
        end
        chk("rvalid_latency", 64'(n + 1), 64'(RL + 1));
        e = exp_r_q.pop_front();
        for (int i = 0; i < rhold; i++) begin
            chk("rvalid_hold", bus.s_rvalid, 1'b1);
            chk("rdata_hold", bus.s_rdata, e.data);
            chk("rresp_hold", bus.s_rresp, e.resp);
            chk("arready_hold", bus.s_arready, 1'b0);
            step();
        end
        chk("rdata", bus.s_rdata, e.data);
        chk("rresp", bus.s_rresp, e.resp);
        bus.s_rready = 1'b1;
        step();
        bus.s_rready = 1'b0;
        chk("rvalid_clear", bus.s_rvalid, 1'b0);
        chk("arready_reopen", bus.s_arready, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.s_awvalid = 1'b0;
        bus.s_awaddr  = 32'h0;
        bus.s_wvalid  = 1'b0;
        bus.s_wdata   = 32'h0;
        bus.s_wstrb   = 4'h0;
        bus.s_bready  = 1'b0;
        bus.s_arvalid = 1'b0;
        bus.s_araddr  = 32'h0;
        bus.s_rready  = 1'b0;
        repeat (3) step();

        chk("rst_awready", bus.s_awready, 1'b0);
        chk("rst_wready", bus.s_wready, 1'b0);
        chk("rst_arready", bus.s_arready, 1'b0);
        chk("rst_bvalid", bus.s_bvalid, 1'b0);
        chk("rst_rvalid", bus.s_rvalid, 1'b0);
        chk("rst_bresp", bus.s_bresp, 2'b00);
        chk("rst_rresp", bus.s_rresp, 2'b00);
        chk("rst_rdata", bus.s_rdata, 32'h0);

        rst = 1'b0;
        step();
        chk("post_rst_awready", bus.s_awready, 1'b1);
        chk("post_rst_wready", bus.s_wready, 1'b1);
        chk("post_rst_arready", bus.s_arready, 1'b1);

        do_write(32'h0000_0000, 32'h0102_0304, 4'hF, 0, 0);
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(32'h0000_0010, 0);

        do_write(32'h0000_0020, 32'h1122_3344, 4'hF, 0, 0);
        do_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0);
        do_read(32'h0000_0020, 0);

        do_write(32'h0000_0030, 32'hCAFE_F00D, 4'hF, 3, 5);
        do_read(32'h0000_0030, 4);

        do_write(32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0);
        do_read(32'h0000_0010, 0);

        do_write(32'h0000_0026, 32'h1234_5678, 4'hF, 0, 0);
        do_read(32'h0000_0024, 0);

        do_write(32'h0000_1000, 32'h55AA_55AA, 4'hF, 0, 0);
        do_read(32'h0000_1000, 0);
        do_read(32'h0000_0000, 0);

        bus.s_araddr  = 32'h0000_0020;
        bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        chk("mid_read_arready_dropped", bus.s_arready, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_read_rvalid", bus.s_rvalid, 1'b0);
            chk("rst_mid_read_arready", bus.s_arready, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("after_mid_rst_arready", bus.s_arready, 1'b1);
        chk("after_mid_rst_rvalid", bus.s_rvalid, 1'b0);
        do_read(32'h0000_0020, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
